hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core (IF/ID/EX/MEM/WB) supporting R-type, lw, sw and beqz. It shadows the destination and control bits of the instructions in EX, MEM and WB. From these it generates stage enables, the EX bubble, the IF/ID flush and the EX operand-forwarding selects. It also owns the data-memory request/acknowledge handshake and freezes the pipeline while a memory access is outstanding.

---
 rtl/hazard_ctrl_if.sv | 39 +++
 rtl/hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID-stage, dmem handshake and stage-control signals of hazard_ctrl
interface hazard_ctrl_if;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd_out;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_beq_taken;
  logic        dmem_ack;
  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        dmem_req;
  logic        wb_we;
  logic [15:0] stall_cnt;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_rd_out, id_reg_write,
           id_mem_read, id_mem_write, id_beq_taken, dmem_ack,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
           id_ex_bubble, fwd_a, fwd_b, dmem_req, wb_we, stall_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_rd_out, id_reg_write,
           id_mem_read, id_mem_write, id_beq_taken, dmem_ack,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
           id_ex_bubble, fwd_a, fwd_b, dmem_req, wb_we, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - five-stage stall/flush/forward and dmem freeze controller; FORWARD_EN enables EX forwarding
module hazard_ctrl (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQZ  = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       reg_write;
    logic       mem_read;
    logic       mem_op;
    logic       done;
  } entry_t;

  typedef enum logic [1:0] {MODE_RUN, MODE_HAZ_STALL, MODE_MEM_WAIT} mode_t;

  entry_t      ex_q, mem_q, wb_q, id_entry;
  logic [4:0]  src_a_q, src_b_q, id_src_a, id_src_b;
  logic        use_a, use_b, is_beqz, hazard, dmem_req;
  logic [15:0] stall_cnt_q;
  mode_t       mode;
  logic        unused_bits;

  function automatic logic hit(input entry_t e, input logic [4:0] src);
    return e.valid && e.reg_write && (e.dst != 5'd0) && (e.dst == src);
  endfunction

  always_comb begin
    use_a = 1'b0;
    use_b = 1'b0;
    if (bus.id_valid) begin
      case (bus.id_opcode)
        OP_RTYPE, OP_SW: begin
          use_a = 1'b1;
          use_b = 1'b1;
        end
        OP_LW, OP_BEQZ: use_a = 1'b1;
        default: ;
      endcase
    end
  end

  // Unused sources are forced to $0 so they can never match a producer.
  assign id_src_a = use_a ? bus.id_rs : 5'd0;
  assign id_src_b = use_b ? bus.id_rt : 5'd0;
  assign is_beqz  = bus.id_valid && (bus.id_opcode == OP_BEQZ);

  always_comb begin
    id_entry           = '0;
    id_entry.valid     = bus.id_valid;
    id_entry.dst       = bus.id_rd_out;
    id_entry.reg_write = bus.id_reg_write;
    id_entry.mem_read  = bus.id_mem_read;
    id_entry.mem_op    = bus.id_mem_read || bus.id_mem_write;
  end

`ifdef FORWARD_EN
  // beqz compares in ID, so it cannot take EX/MEM forwarding and must wait.
  assign hazard = (ex_q.mem_read && (hit(ex_q, id_src_a) || hit(ex_q, id_src_b))) ||
                  (is_beqz && (hit(ex_q, id_src_a) || hit(mem_q, id_src_a)));
  assign bus.fwd_a = hit(mem_q, src_a_q) ? 2'b01 : (hit(wb_q, src_a_q) ? 2'b10 : 2'b00);
  assign bus.fwd_b = hit(mem_q, src_b_q) ? 2'b01 : (hit(wb_q, src_b_q) ? 2'b10 : 2'b00);
`else
  assign hazard = hit(ex_q, id_src_a) || hit(ex_q, id_src_b) ||
                  hit(mem_q, id_src_a) || hit(mem_q, id_src_b);
  assign bus.fwd_a = 2'b00;
  assign bus.fwd_b = 2'b00;
`endif

  assign dmem_req     = mem_q.valid && mem_q.mem_op;
  assign bus.dmem_req = dmem_req;
  assign bus.wb_we    = wb_q.valid && wb_q.reg_write && !wb_q.done;
  assign bus.stall_cnt = stall_cnt_q;

  always_comb begin
    mode = MODE_RUN;
    if (dmem_req && !bus.dmem_ack) begin
      mode = MODE_MEM_WAIT;
    end else if (hazard) begin
      mode = MODE_HAZ_STALL;
    end
  end

  always_comb begin
    bus.pc_en        = 1'b1;
    bus.if_id_en     = 1'b1;
    bus.id_ex_en     = 1'b1;
    bus.ex_mem_en    = 1'b1;
    bus.mem_wb_en    = 1'b1;
    bus.id_ex_bubble = 1'b0;
    case (mode)
      MODE_MEM_WAIT: begin
        bus.pc_en     = 1'b0;
        bus.if_id_en  = 1'b0;
        bus.id_ex_en  = 1'b0;
        bus.ex_mem_en = 1'b0;
        bus.mem_wb_en = 1'b0;
      end
      MODE_HAZ_STALL: begin
        bus.pc_en        = 1'b0;
        bus.if_id_en     = 1'b0;
        bus.id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
    bus.if_id_flush = reset && (mode == MODE_RUN) && is_beqz && bus.id_beq_taken;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      src_a_q     <= 5'd0;
      src_b_q     <= 5'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      if ((mode != MODE_RUN) && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      // While frozen WB stays put but must not strobe the regfile again.
      if (mode == MODE_MEM_WAIT) begin
        if (wb_q.valid) begin
          wb_q.done <= 1'b1;
        end
      end else begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        if (mode == MODE_RUN) begin
          ex_q    <= id_entry;
          src_a_q <= id_src_a;
          src_b_q <= id_src_b;
        end else begin
          ex_q    <= '0;
          src_a_q <= 5'd0;
          src_b_q <= 5'd0;
        end
      end
    end
  end

  assign unused_bits = ^{ex_q.done, mem_q.done, wb_q.dst, wb_q.mem_read, wb_q.mem_op,
                         src_a_q, src_b_q};
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQZ = 6'b000100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
`ifdef FORWARD_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   passed = 0;
  int   total = 0;

  hazard_ctrl_if bus();
  hazard_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic rw,
                        input logic mr, input logic mw, input logic bt);
    bus.id_valid     = v;
    bus.id_opcode    = op;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_rd_out    = rd;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.id_mem_write = mw;
    bus.id_beq_taken = bt;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_id(0, OP_R, 0, 0, 0, 0, 0, 0, 0);
    bus.dmem_ack = 1'b1;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] v;
    reset = 1'b0;
    set_id(0, OP_R, 0, 0, 0, 0, 0, 0, 0);
    bus.dmem_ack = 1'b1;
    #3;
    v = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en, bus.if_id_flush,
         bus.id_ex_bubble, bus.fwd_a, bus.fwd_b, bus.dmem_req, bus.wb_we};
    total++;
    if (v !== 13'b11111_00000000) $display("FAIL reset_outputs got %b exp %b", v, 13'b11111_00000000);
    else passed++;
    total++;
    if (bus.stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt got %0d exp 0", bus.stall_cnt);
    else passed++;
    step();
    reset = 1'b1;
  endtask

  task automatic test_rtype_dep();
    int stalls;
    do_reset();
    set_id(1, OP_R, 1, 2, 3, 1, 0, 0, 0);
    #1;
    total++;
    if (bus.pc_en !== 1'b1) $display("FAIL rtype_first_run got %b exp 1", bus.pc_en);
    else passed++;
    step();
    set_id(1, OP_R, 3, 5, 4, 1, 0, 0, 0);
    #1;
    stalls = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.pc_en === 1'b1) break;
      stalls++;
      step();
    end
    total++;
    if (stalls !== (FE ? 0 : 2)) $display("FAIL rtype_stalls got %0d exp %0d", stalls, (FE ? 0 : 2));
    else passed++;
    step();
    set_id(0, OP_R, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if (bus.fwd_a !== (FE ? 2'b01 : 2'b00)) $display("FAIL rtype_fwd_a got %b exp %b", bus.fwd_a, (FE ? 2'b01 : 2'b00));
    else passed++;
    total++;
    if (bus.stall_cnt !== (FE ? 16'd0 : 16'd2)) $display("FAIL rtype_stall_cnt got %0d exp %0d", bus.stall_cnt, (FE ? 0 : 2));
    else passed++;
  endtask

  task automatic test_load_use();
    int stalls;
    do_reset();
    set_id(1, OP_LW, 1, 2, 2, 1, 1, 0, 0);
    step();
    set_id(1, OP_R, 2, 3, 4, 1, 0, 0, 0);
    #1;
    total++;
    if ({bus.pc_en, bus.id_ex_bubble} !== 2'b01) $display("FAIL load_use_stall got %b exp 01", {bus.pc_en, bus.id_ex_bubble});
    else passed++;
    stalls = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.pc_en === 1'b1) break;
      stalls++;
      step();
    end
    total++;
    if (stalls !== (FE ? 1 : 2)) $display("FAIL load_use_stalls got %0d exp %0d", stalls, (FE ? 1 : 2));
    else passed++;
    step();
    set_id(0, OP_R, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if (bus.fwd_a !== (FE ? 2'b10 : 2'b00)) $display("FAIL load_use_fwd_a got %b exp %b", bus.fwd_a, (FE ? 2'b10 : 2'b00));
    else passed++;
    total++;
    if (bus.stall_cnt !== (FE ? 16'd1 : 16'd2)) $display("FAIL load_use_stall_cnt got %0d exp %0d", bus.stall_cnt, (FE ? 1 : 2));
    else passed++;
  endtask

  task automatic test_beqz();
    do_reset();
    set_id(1, OP_BEQZ, 0, 0, 0, 0, 0, 0, 1);
    #1;
    total++;
    if ({bus.if_id_flush, bus.pc_en} !== 2'b11) $display("FAIL beqz_flush got %b exp 11", {bus.if_id_flush, bus.pc_en});
    else passed++;
    step();
    set_id(1, OP_R, 1, 2, 3, 1, 0, 0, 0);
    #1;
    total++;
    if (bus.if_id_flush !== 1'b0) $display("FAIL beqz_flush_one_cycle got %b exp 0", bus.if_id_flush);
    else passed++;
    step();
    set_id(1, OP_BEQZ, 3, 0, 0, 0, 0, 0, 1);
    #1;
    total++;
    if ({bus.if_id_flush, bus.pc_en} !== 2'b00) $display("FAIL beqz_stall_ex got %b exp 00", {bus.if_id_flush, bus.pc_en});
    else passed++;
    step();
    total++;
    if ({bus.if_id_flush, bus.pc_en} !== 2'b00) $display("FAIL beqz_stall_mem got %b exp 00", {bus.if_id_flush, bus.pc_en});
    else passed++;
    step();
    total++;
    if ({bus.if_id_flush, bus.pc_en} !== 2'b11) $display("FAIL beqz_after_stall got %b exp 11", {bus.if_id_flush, bus.pc_en});
    else passed++;
  endtask

  task automatic test_slow_mem();
    int req_n, frz_n, we_n;
    do_reset();
    bus.dmem_ack = 1'b0;
    set_id(1, OP_R, 1, 2, 6, 1, 0, 0, 0);
    step();
    set_id(1, OP_SW, 8, 7, 0, 0, 0, 1, 0);
    step();
    set_id(0, OP_R, 0, 0, 0, 0, 0, 0, 0);
    step();
    req_n = 0;
    frz_n = 0;
    we_n = 0;
    for (int i = 0; i < 5; i++) begin
      bus.dmem_ack = (i == 3);
      #1;
      if (bus.dmem_req === 1'b1) req_n++;
      if ({bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en} === 5'b0) frz_n++;
      if (bus.wb_we === 1'b1) we_n++;
      step();
    end
    bus.dmem_ack = 1'b1;
    total++;
    if (req_n !== 4) $display("FAIL slow_mem_req_cycles got %0d exp 4", req_n);
    else passed++;
    total++;
    if (frz_n !== 3) $display("FAIL slow_mem_freeze_cycles got %0d exp 3", frz_n);
    else passed++;
    total++;
    if (we_n !== 1) $display("FAIL slow_mem_wb_we_pulses got %0d exp 1", we_n);
    else passed++;
    total++;
    if (bus.stall_cnt !== 16'd3) $display("FAIL slow_mem_stall_cnt got %0d exp 3", bus.stall_cnt);
    else passed++;
  endtask

  task automatic test_reg0();
    do_reset();
    set_id(1, OP_LW, 1, 0, 0, 1, 1, 0, 0);
    step();
    set_id(1, OP_R, 0, 0, 5, 1, 0, 0, 0);
    #1;
    total++;
    if (bus.pc_en !== 1'b1) $display("FAIL reg0_no_stall got %b exp 1", bus.pc_en);
    else passed++;
    step();
    set_id(0, OP_R, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if ({bus.fwd_a, bus.fwd_b} !== 4'b0000) $display("FAIL reg0_fwd got %b exp 0000", {bus.fwd_a, bus.fwd_b});
    else passed++;
    total++;
    if (bus.stall_cnt !== 16'd0) $display("FAIL reg0_stall_cnt got %0d exp 0", bus.stall_cnt);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int stalls;
    do_reset();
    set_id(1, OP_R, 1, 2, 3, 1, 0, 0, 0);
    step();
    set_id(1, OP_R, 4, 5, 3, 1, 0, 0, 0);
    #1;
    total++;
    if (bus.pc_en !== 1'b1) $display("FAIL b2b_independent got %b exp 1", bus.pc_en);
    else passed++;
    step();
    set_id(1, OP_R, 1, 3, 6, 1, 0, 0, 0);
    #1;
    stalls = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.pc_en === 1'b1) break;
      stalls++;
      step();
    end
    total++;
    if (stalls !== (FE ? 0 : 2)) $display("FAIL b2b_stalls got %0d exp %0d", stalls, (FE ? 0 : 2));
    else passed++;
    step();
    set_id(0, OP_R, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++;
    if ({bus.fwd_a, bus.fwd_b} !== (FE ? 4'b0001 : 4'b0000)) $display("FAIL b2b_mem_priority got %b exp %b", {bus.fwd_a, bus.fwd_b}, (FE ? 4'b0001 : 4'b0000));
    else passed++;
  endtask

  task automatic test_reset_mid_freeze();
    do_reset();
    bus.dmem_ack = 1'b0;
    set_id(1, OP_SW, 8, 7, 0, 0, 0, 1, 0);
    step();
    set_id(0, OP_R, 0, 0, 0, 0, 0, 0, 0);
    step();
    total++;
    if ({bus.dmem_req, bus.pc_en} !== 2'b10) $display("FAIL freeze_entered got %b exp 10", {bus.dmem_req, bus.pc_en});
    else passed++;
    step();
    reset = 1'b0;
    #1;
    total++;
    if (bus.dmem_req !== 1'b0) $display("FAIL reset_drops_req got %b exp 0", bus.dmem_req);
    else passed++;
    total++;
    if ({bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en} !== 5'b11111)
      $display("FAIL reset_enables got %b exp 11111", {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en});
    else passed++;
    total++;
    if (bus.stall_cnt !== 16'd0) $display("FAIL reset_clears_cnt got %0d exp 0", bus.stall_cnt);
    else passed++;
    step();
    reset = 1'b1;
    bus.dmem_ack = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rtype_dep();
    test_load_use();
    test_beqz();
    test_slow_mem();
    test_reg0();
    test_back_to_back();
    test_reset_mid_freeze();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
